idex_hazard_ctrl: RTL and testbench

- Consumer-side control for the ID/EX pipeline buffer. Inspects the instruction in IF/ID against the destination fields latched in ID/EX and EX/MEM.
- Decides when to freeze PC and IF/ID and inject a bubble into ID/EX (all control bits zeroed), and when to flush IF/ID after a taken branch.
- Holds multi-cycle stalls in a small FSM and keeps a saturating stall-cycle counter for performance readout.

---
 rtl/idex_hazard_ctrl_pkg.sv | 16 +
 rtl/idex_hazard_ctrl_reg_match.sv | 20 ++
 rtl/idex_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_idex_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
package idex_hazard_ctrl_pkg;

    typedef enum logic {
        RUN,
        HOLD
    } hz_state_e;

    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/idex_hazard_ctrl_reg_match.sv
// Source-vs-destination register compare; register 0 never matches, and a
// dual-issue producer also claims dest+1 (5-bit wrap).
module idex_hazard_ctrl_reg_match
    import idex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] dest,
    input  logic       use_double,
    output logic       match
);

    logic [4:0] dest_next;
    logic       hit_second;

    assign dest_next  = dest + 5'd1;
    // dest=31 wraps the second write to r0, which is never a real dependency
    assign hit_second = use_double && (src == dest_next) && (dest_next != ZERO_REG);
    assign match      = (dest != ZERO_REG) && ((src == dest) || hit_second);

endmodule

// File: rtl/idex_hazard_ctrl.sv
// Hazard control for the ID/EX buffer: stall/bubble, branch flush, and a
// saturating stall-cycle counter.
module idex_hazard_ctrl
    import idex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      IFID_Instruction,
    input  logic             UsesRt,
    input  logic             BranchID,
    input  logic             BranchTaken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_WriteReg,
    input  logic             IDEX_Double,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_WriteReg,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] StallCount
);

    hz_state_e  state_q;
    logic [4:0] rs, rt;
    logic       ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic       ex_hit, mem_hit;
    logic [1:0] need;
    logic       stall;
    logic       unused_instr;

    assign rs           = IFID_Instruction[RS_HI:RS_LO];
    assign rt           = IFID_Instruction[RT_HI:RT_LO];
    assign unused_instr = ^{IFID_Instruction[31:26], IFID_Instruction[15:0]};

    idex_hazard_ctrl_reg_match u_ex_rs (
        .src        (rs),
        .dest       (IDEX_WriteReg),
        .use_double (IDEX_Double),
        .match      (ex_rs_hit)
    );

    idex_hazard_ctrl_reg_match u_ex_rt (
        .src        (rt),
        .dest       (IDEX_WriteReg),
        .use_double (IDEX_Double),
        .match      (ex_rt_hit)
    );

    idex_hazard_ctrl_reg_match u_mem_rs (
        .src        (rs),
        .dest       (EXMEM_WriteReg),
        .use_double (1'b0),
        .match      (mem_rs_hit)
    );

    idex_hazard_ctrl_reg_match u_mem_rt (
        .src        (rt),
        .dest       (EXMEM_WriteReg),
        .use_double (1'b0),
        .match      (mem_rt_hit)
    );

    assign ex_hit  = ex_rs_hit || (UsesRt && ex_rt_hit);
    assign mem_hit = mem_rs_hit || (UsesRt && mem_rt_hit);

    always_comb begin
        need = 2'd0;
        if (BranchID && IDEX_MemRead && ex_hit) begin
            need = 2'd2;
        end else if (BranchID && IDEX_RegWrite && ex_hit) begin
            need = 2'd1;
        end else if (BranchID && EXMEM_MemRead && mem_hit) begin
            need = 2'd1;
        end else if (IDEX_MemRead && ex_hit) begin
            need = 2'd1;
        end
    end

    // Reset forces the stall pattern so nothing enters the pipe while held.
    assign stall       = Rst || (state_q == HOLD) || (need != 2'd0);
    assign PCWrite     = !stall;
    assign IFID_Write  = !stall;
    assign IDEX_Bubble = stall;
    assign IFID_Flush  = !stall && BranchID && BranchTaken;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= RUN;
            StallCount <= '0;
        end else begin
            unique case (state_q)
                RUN:     state_q <= (need == 2'd2) ? HOLD : RUN;
                HOLD:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
            if (stall && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Randomized + directed bench for idex_hazard_ctrl against a rule-level model.
module tb_idex_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IFID_Instruction;
    logic        UsesRt, BranchID, BranchTaken;
    logic        IDEX_MemRead, IDEX_RegWrite, IDEX_Double, EXMEM_MemRead;
    logic [4:0]  IDEX_WriteReg, EXMEM_WriteReg;
    logic        PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
    logic [15:0] StallCount;

    idex_hazard_ctrl #(.CNT_W(16)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .IFID_Instruction (IFID_Instruction),
        .UsesRt           (UsesRt),
        .BranchID         (BranchID),
        .BranchTaken      (BranchTaken),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_RegWrite    (IDEX_RegWrite),
        .IDEX_WriteReg    (IDEX_WriteReg),
        .IDEX_Double      (IDEX_Double),
        .EXMEM_MemRead    (EXMEM_MemRead),
        .EXMEM_WriteReg   (EXMEM_WriteReg),
        .PCWrite          (PCWrite),
        .IFID_Write       (IFID_Write),
        .IDEX_Bubble      (IDEX_Bubble),
        .IFID_Flush       (IFID_Flush),
        .StallCount       (StallCount)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    // model state: "one more forced stall cycle owed" and the stall tally
    bit m_owed = 1'b0;
    int m_count = 0;
    int e_need;
    bit e_stall;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input int rx, input int d, input bit dbl);
        if (d == 0) return 1'b0;
        if (rx == d) return 1'b1;
        return dbl && (((d + 1) % 32) != 0) && (rx == (d + 1) % 32);
    endfunction

    // Evaluate the rules on current inputs and compare every output.
    task automatic settle();
        int rs, rt;
        bit ex, mem;
        #2;
        rs  = int'(IFID_Instruction[25:21]);
        rt  = int'(IFID_Instruction[20:16]);
        ex  = hit(rs, IDEX_WriteReg, IDEX_Double) || (UsesRt && hit(rt, IDEX_WriteReg, IDEX_Double));
        mem = hit(rs, EXMEM_WriteReg, 1'b0) || (UsesRt && hit(rt, EXMEM_WriteReg, 1'b0));
        if (BranchID && IDEX_MemRead && ex) e_need = 2;
        else if (BranchID && IDEX_RegWrite && ex) e_need = 1;
        else if (BranchID && EXMEM_MemRead && mem) e_need = 1;
        else if (IDEX_MemRead && ex) e_need = 1;
        else e_need = 0;
        e_stall = Rst || m_owed || (e_need > 0);
        chk("pcwrite", PCWrite, !e_stall);
        chk("ifid_write", IFID_Write, !e_stall);
        chk("bubble", IDEX_Bubble, e_stall);
        chk("flush", IFID_Flush, !e_stall && BranchID && BranchTaken);
        chk("count", StallCount, Rst ? 0 : m_count);
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Rst) begin
            m_owed  = 1'b0;
            m_count = 0;
        end else begin
            if (e_stall && m_count < 65535) m_count++;
            m_owed = !m_owed && (e_need == 2);
        end
        #1;
    endtask

    task automatic clear_in();
        IFID_Instruction = 32'h0; UsesRt = 0; BranchID = 0; BranchTaken = 0;
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0; IDEX_Double = 0;
        EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt);
        IFID_Instruction = $urandom;
        IFID_Instruction[25:21] = rs;
        IFID_Instruction[20:16] = rt;
    endtask

    task automatic do_reset();
        Rst = 1'b1; clear_in(); settle(); tick();
        Rst = 1'b0;
    endtask

    int regs[8] = '{0, 1, 8, 9, 12, 13, 30, 31};

    initial begin
        Rst = 1'b1;
        clear_in();
        #1;
        settle();
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_bubble", IDEX_Bubble, 1);
        tick();
        Rst = 1'b0;
        settle();
        chk("rst_count", StallCount, 0);
        chk("rst_release_pc", PCWrite, 1);
        tick();

        // load-use
        do_reset();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 8; set_id(5'd8, 5'd3);
        settle();
        chk("lu_pc", PCWrite, 0);
        chk("lu_bubble", IDEX_Bubble, 1);
        tick();
        clear_in(); set_id(5'd8, 5'd3);
        settle();
        chk("lu_after_pc", PCWrite, 1);
        chk("lu_count", StallCount, 1);
        tick();

        // branch after load: two stalls
        do_reset();
        BranchID = 1; UsesRt = 1; IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 9;
        set_id(5'd4, 5'd9);
        settle(); chk("bl_c1_pc", PCWrite, 0); tick();
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
        EXMEM_MemRead = 1; EXMEM_WriteReg = 9;
        settle(); chk("bl_c2_pc", PCWrite, 0); tick();
        EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
        settle(); chk("bl_c3_pc", PCWrite, 1); chk("bl_count", StallCount, 2); tick();

        // branch after ALU op, then flush
        do_reset();
        BranchID = 1; BranchTaken = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 10; set_id(5'd10, 5'd2);
        settle(); chk("ba_pc", PCWrite, 0); chk("ba_noflush", IFID_Flush, 0); tick();
        IDEX_RegWrite = 0; IDEX_WriteReg = 0;
        settle(); chk("ba_flush", IFID_Flush, 1); chk("ba_pc2", PCWrite, 1); tick();

        // Double and zero-register corners
        clear_in(); IDEX_Double = 1; IDEX_MemRead = 1; IDEX_WriteReg = 12; set_id(5'd13, 5'd0);
        settle(); chk("dbl_hit", PCWrite, 0); tick();
        IDEX_WriteReg = 31; set_id(5'd0, 5'd0);
        settle(); chk("dbl_wrap0", PCWrite, 1); tick();
        IDEX_Double = 0; IDEX_WriteReg = 0;
        settle(); chk("zero_dest", PCWrite, 1); tick();

        // reset asserted mid-HOLD
        clear_in();
        BranchID = 1; IDEX_MemRead = 1; IDEX_WriteReg = 9; set_id(5'd9, 5'd1);
        settle(); tick();
        clear_in();
        Rst = 1'b1;
        settle();
        chk("hold_rst_pc", PCWrite, 0);
        chk("hold_rst_cnt", StallCount, 0);
        tick();
        Rst = 1'b0;
        settle(); chk("hold_rel_pc", PCWrite, 1); chk("hold_rel_cnt", StallCount, 0); tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Rst = ($urandom_range(0, 49) == 0);
            set_id(5'(regs[$urandom_range(0, 7)]), 5'(regs[$urandom_range(0, 7)]));
            UsesRt = $urandom; BranchID = $urandom; BranchTaken = $urandom;
            IDEX_MemRead = $urandom; IDEX_RegWrite = $urandom; IDEX_Double = $urandom;
            EXMEM_MemRead = $urandom;
            IDEX_WriteReg = 5'(regs[$urandom_range(0, 7)]);
            EXMEM_WriteReg = 5'(regs[$urandom_range(0, 7)]);
            settle();
            tick();
        end
        Rst = 1'b0;

        // saturation
        do_reset();
        IDEX_MemRead = 1; IDEX_WriteReg = 8; set_id(5'd8, 5'd0);
        for (int i = 0; i < 65540; i++) begin
            settle();
            tick();
        end
        settle();
        chk("sat_count", StallCount, 16'hFFFF);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
